// File: rtl/audio_sample_feeder_if.sv
// audio_sample_feeder_if
//   Groups the two data-path handshakes of the sample feeder:
//   - write port from the storage/decoder side (valid/ready, one stereo frame per beat)
//   - sample port towards the I2S master (send/done, one stereo frame per transfer)
//   Signal suffixes (_i/_o) are named from the feeder's point of view.
//
// Modports
//   slave  : the feeder itself (accepts writes, offers frames to the I2S master)
//   master : the surrounding system (producer plus I2S master)
interface audio_sample_feeder_if #(
    parameter int DATA_BITS = 16
);
    logic [DATA_BITS-1:0] wr_data_L_i;
    logic [DATA_BITS-1:0] wr_data_R_i;
    logic                 wr_valid_i;
    logic                 wr_ready_o;

    logic [DATA_BITS-1:0] i2s_sample_data_L_o;
    logic [DATA_BITS-1:0] i2s_sample_data_R_o;
    logic                 i2s_send_o;
    logic                 i2s_done_i;

    modport slave (
        input  wr_data_L_i, wr_data_R_i, wr_valid_i, i2s_done_i,
        output wr_ready_o, i2s_sample_data_L_o, i2s_sample_data_R_o, i2s_send_o
    );

    modport master (
        output wr_data_L_i, wr_data_R_i, wr_valid_i, i2s_done_i,
        input  wr_ready_o, i2s_sample_data_L_o, i2s_sample_data_R_o, i2s_send_o
    );
endinterface

// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder
//   Stereo sample FIFO and playback controller placed directly upstream of the
//   I2S master. Frames pushed on the write port are buffered; once enough frames
//   are stored the FIFO head is offered to the I2S master with volume
//   attenuation and mute applied. Prefill, underrun detection and flush keep the
//   codec from ever seeing stale data.
//
// Ports
//   clk, rst        : system clock (shared with the I2S master), async active-high reset
//   sif (slave)     : write port (wr_data_L/R, wr_valid, wr_ready) and
//                     I2S sample port (i2s_sample_data_L/R, i2s_send, i2s_done)
//   play_i          : level, 1 = play, 0 = stop
//   flush_i         : single-cycle pulse emptying the FIFO
//   mute_i          : force output samples to zero (frames are still consumed)
//   vol_shift_i     : arithmetic right-shift attenuation 0..15
//   fifo_level_o    : frames currently stored (registered)
//   underrun_cnt_o  : saturating count of transfers taken from an empty FIFO
//   playing_o       : high while in the PLAY state
module audio_sample_feeder #(
    parameter int DATA_BITS   = 16,
    parameter int DEPTH       = 64,
    parameter int START_LEVEL = 32,
    parameter int CNT_BITS    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    audio_sample_feeder_if.slave     sif,
    input  logic                     play_i,
    input  logic                     flush_i,
    input  logic                     mute_i,
    input  logic [3:0]               vol_shift_i,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic [CNT_BITS-1:0]      underrun_cnt_o,
    output logic                     playing_o
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int LVL_BITS = PTR_BITS + 1;
    localparam logic [LVL_BITS-1:0] FULL_LEVEL  = LVL_BITS'(DEPTH);
    localparam logic [LVL_BITS-1:0] START_LVL   = LVL_BITS'(START_LEVEL);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        FILL = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_BITS-1:0]   level_q, level_d;
    logic [CNT_BITS-1:0]   underrun_cnt_q, underrun_cnt_d;
    logic                  send_q, send_d;
    logic                  playing_q, playing_d;

    logic [DATA_BITS-1:0]  mem_l [DEPTH];
    logic [DATA_BITS-1:0]  mem_r [DEPTH];

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  transfer;
    logic                  pop;
    logic                  underrun;
    logic signed [DATA_BITS-1:0] head_l;
    logic signed [DATA_BITS-1:0] head_r;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LEVEL);

    // Ready drops during a flush so the simultaneous write is cleanly refused.
    assign sif.wr_ready_o = !fifo_full && !flush_i;
    assign push           = sif.wr_valid_i && sif.wr_ready_o;

    // A transfer from an empty FIFO is an underrun, even if a push lands in the
    // same cycle: the pushed frame is not at the head until the next cycle.
    assign transfer = send_q && sif.i2s_done_i;
    assign pop      = transfer && !fifo_empty;
    assign underrun = transfer && fifo_empty;

    // Pointer and level bookkeeping; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_BITS'(1);
                2'b01:   level_d = level_q - LVL_BITS'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Underrun counter sticks at all-ones rather than wrapping back to zero.
    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (underrun && (underrun_cnt_q != '1)) begin
            underrun_cnt_d = underrun_cnt_q + CNT_BITS'(1);
        end
    end

    // Playback FSM. Stopping wins over everything, then flush, then underrun.
    // Flush with play held keeps FILL in FILL so the emptied FIFO is refilled
    // before playback resumes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP: begin
                if (play_i) state_d = FILL;
            end
            FILL: begin
                if (!play_i)                           state_d = STOP;
                else if (!flush_i && level_q >= START_LVL) state_d = PLAY;
            end
            PLAY: begin
                if (!play_i)                  state_d = STOP;
                else if (flush_i || underrun) state_d = FILL;
            end
            default: state_d = STOP;
        endcase
        send_d    = (state_d == PLAY);
        playing_d = (state_d == PLAY);
    end

    // Control state with asynchronous reset so send drops immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= STOP;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            underrun_cnt_q <= '0;
            send_q         <= 1'b0;
            playing_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            underrun_cnt_q <= underrun_cnt_d;
            send_q         <= send_d;
            playing_q      <= playing_d;
        end
    end

    // Sample storage needs no reset: an empty FIFO always outputs zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr_q] <= sif.wr_data_L_i;
            mem_r[wr_ptr_q] <= sif.wr_data_R_i;
        end
    end

    assign head_l = mem_l[rd_ptr_q];
    assign head_r = mem_r[rd_ptr_q];

    // Attenuation is a sign-preserving shift; mute or an empty FIFO gives silence.
    always_comb begin
        sif.i2s_sample_data_L_o = '0;
        sif.i2s_sample_data_R_o = '0;
        if (!mute_i && !fifo_empty) begin
            sif.i2s_sample_data_L_o = head_l >>> vol_shift_i;
            sif.i2s_sample_data_R_o = head_r >>> vol_shift_i;
        end
    end

    assign sif.i2s_send_o    = send_q;
    assign playing_o         = playing_q;
    assign fifo_level_o      = level_q;
    assign underrun_cnt_o    = underrun_cnt_q;
endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb_audio_sample_feeder
//   Drives directed scenarios (prefill, streaming, attenuation/mute, flush,
//   underrun, full/wrap, reset mid-playback) followed by randomized traffic.
//   A queue-based reference model predicts every output each cycle.
module tb_audio_sample_feeder;
    localparam int DATA_BITS   = 16;
    localparam int DEPTH       = 64;
    localparam int START_LEVEL = 32;
    localparam int CNT_BITS    = 16;
    localparam int LVL_BITS    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    logic play_i;
    logic flush_i;
    logic mute_i;
    logic [3:0] vol_shift_i;
    logic [LVL_BITS-1:0] fifo_level_o;
    logic [CNT_BITS-1:0] underrun_cnt_o;
    logic playing_o;

    audio_sample_feeder_if #(.DATA_BITS(DATA_BITS)) bus ();

    audio_sample_feeder #(
        .DATA_BITS   (DATA_BITS),
        .DEPTH       (DEPTH),
        .START_LEVEL (START_LEVEL),
        .CNT_BITS    (CNT_BITS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sif            (bus),
        .play_i         (play_i),
        .flush_i        (flush_i),
        .mute_i         (mute_i),
        .vol_shift_i    (vol_shift_i),
        .fifo_level_o   (fifo_level_o),
        .underrun_cnt_o (underrun_cnt_o),
        .playing_o      (playing_o)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {L,R} frames, the playback state and the
    // underrun count, advanced once per clock from the applied inputs.
    typedef enum int { M_STOP, M_FILL, M_PLAY } mstate_t;
    logic [31:0] q[$];
    mstate_t m_state;
    int m_ucnt;

    logic cur_play;
    logic cur_mute;
    logic [3:0] cur_shift;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Attenuation as floor division by 2^sh, which is what a sign-preserving
    // right shift means for two's complement values.
    function automatic logic [15:0] attenuate(input logic [15:0] s, input int sh);
        int v;
        int d;
        v = int'($signed(s));
        d = 1 << sh;
        if (v >= 0) v = v / d;
        else        v = -((-v + d - 1) / d);
        return v[15:0];
    endfunction

    task automatic resetModel();
        q.delete();
        m_state = M_STOP;
        m_ucnt  = 0;
    endtask

    // One clock cycle: apply inputs, compare all outputs against the model,
    // advance the model, then wait for the edge. Entered and left at posedge+1.
    task automatic applyStimulus(input logic valid, input logic [15:0] l, input logic [15:0] r,
                                 input logic flush, input logic done);
        int sz;
        logic empty;
        logic exp_ready;
        logic push;
        logic transfer;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        mstate_t nxt;

        bus.wr_valid_i  = valid;
        bus.wr_data_L_i = l;
        bus.wr_data_R_i = r;
        bus.i2s_done_i  = done;
        flush_i         = flush;
        play_i          = cur_play;
        mute_i          = cur_mute;
        vol_shift_i     = cur_shift;
        #1;

        sz        = q.size();
        empty     = (sz == 0);
        exp_ready = (sz != DEPTH) && !flush;
        exp_l     = 16'h0;
        exp_r     = 16'h0;
        if (!cur_mute && !empty) begin
            exp_l = attenuate(q[0][31:16], int'(cur_shift));
            exp_r = attenuate(q[0][15:0], int'(cur_shift));
        end

        checkOutput("level",    32'(fifo_level_o), 32'(sz));
        checkOutput("ready",    32'(bus.wr_ready_o), 32'(exp_ready));
        checkOutput("send",     32'(bus.i2s_send_o), 32'(m_state == M_PLAY));
        checkOutput("playing",  32'(playing_o), 32'(m_state == M_PLAY));
        checkOutput("underrun", 32'(underrun_cnt_o), 32'(m_ucnt));
        checkOutput("data_L",   32'(bus.i2s_sample_data_L_o), 32'(exp_l));
        checkOutput("data_R",   32'(bus.i2s_sample_data_R_o), 32'(exp_r));

        push     = valid && exp_ready;
        transfer = (m_state == M_PLAY) && done;
        if (transfer && empty && m_ucnt < 65535) m_ucnt++;

        nxt = m_state;
        case (m_state)
            M_STOP: if (cur_play) nxt = M_FILL;
            M_FILL: begin
                if (!cur_play) nxt = M_STOP;
                else if (!flush && sz >= START_LEVEL) nxt = M_PLAY;
            end
            M_PLAY: begin
                if (!cur_play) nxt = M_STOP;
                else if (flush || (transfer && empty)) nxt = M_FILL;
            end
            default: nxt = M_STOP;
        endcase

        if (flush) begin
            q.delete();
        end else begin
            if (transfer && !empty) void'(q.pop_front());
            if (push) q.push_back({l, r});
        end

        @(posedge clk);
        #1;
        m_state = nxt;
    endtask

    task automatic pushRandom(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst             = 1'b1;
        cur_play        = 1'b0;
        cur_mute        = 1'b0;
        cur_shift       = 4'd0;
        play_i          = 1'b0;
        flush_i         = 1'b0;
        mute_i          = 1'b0;
        vol_shift_i     = 4'd0;
        bus.wr_valid_i  = 1'b0;
        bus.wr_data_L_i = '0;
        bus.wr_data_R_i = '0;
        bus.i2s_done_i  = 1'b0;
        resetModel();

        #12;
        checkOutput("rst_level",    32'(fifo_level_o), 32'd0);
        checkOutput("rst_send",     32'(bus.i2s_send_o), 32'd0);
        checkOutput("rst_playing",  32'(playing_o), 32'd0);
        checkOutput("rst_underrun", 32'(underrun_cnt_o), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] prefill");
        cur_play = 1'b1;
        applyStimulus(1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0);
        pushRandom(30);
        idle(1);
        checkOutput("prefill_hold", 32'(bus.i2s_send_o), 32'd0);
        pushRandom(1);
        idle(1);
        checkOutput("prefill_send", 32'(bus.i2s_send_o), 32'd1);
        checkOutput("prefill_L",    32'(bus.i2s_sample_data_L_o), 32'h1234);
        checkOutput("prefill_R",    32'(bus.i2s_sample_data_R_o), 32'hABCD);

        $display("[TB] streaming");
        pushRandom(8);
        for (int p = 0; p < 10; p++) begin
            idle(19);
            applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        end
        checkOutput("stream_level",    32'(fifo_level_o), 32'd30);
        checkOutput("stream_underrun", 32'(underrun_cnt_o), 32'd0);

        $display("[TB] flush in play");
        applyStimulus(1'b1, 16'h5555, 16'h5555, 1'b1, 1'b0);
        checkOutput("flush_level",   32'(fifo_level_o), 32'd0);
        checkOutput("flush_playing", 32'(playing_o), 32'd0);

        $display("[TB] attenuation and mute");
        applyStimulus(1'b1, 16'h8000, 16'h0123, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h4000, 16'hFFF0, 1'b0, 1'b0);
        pushRandom(30);
        idle(1);
        cur_shift   = 4'd3;
        vol_shift_i = 4'd3;
        #1;
        checkOutput("atten_neg_L", 32'(bus.i2s_sample_data_L_o), 32'hF000);
        checkOutput("atten_R",     32'(bus.i2s_sample_data_R_o), 32'h0024);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        checkOutput("atten_pos_L", 32'(bus.i2s_sample_data_L_o), 32'h0800);
        checkOutput("atten_neg_R", 32'(bus.i2s_sample_data_R_o), 32'hFFFE);
        cur_mute = 1'b1;
        mute_i   = 1'b1;
        #1;
        checkOutput("mute_L", 32'(bus.i2s_sample_data_L_o), 32'h0);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        checkOutput("mute_pop_level", 32'(fifo_level_o), 32'd30);
        cur_mute = 1'b0;

        $display("[TB] underrun");
        for (int i = 0; i < DEPTH + 4 && q.size() > 0; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        checkOutput("underrun_cnt",  32'(underrun_cnt_o), 32'd1);
        checkOutput("underrun_send", 32'(bus.i2s_send_o), 32'd0);
        pushRandom(START_LEVEL);
        idle(1);
        checkOutput("refill_playing", 32'(playing_o), 32'd1);

        $display("[TB] full, simultaneous push/pop, wrap");
        cur_play = 1'b0;
        for (int i = 0; i < DEPTH + 4 && q.size() < DEPTH; i++) pushRandom(1);
        bus.wr_valid_i = 1'b1;
        #1;
        checkOutput("full_ready", 32'(bus.wr_ready_o), 32'd0);
        cur_play = 1'b1;
        for (int i = 0; i < 4 * DEPTH && q.size() > 10; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h7777, 16'h8888, 1'b0, 1'b1);
        checkOutput("pushpop_level", 32'(fifo_level_o), 32'd10);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 2000; c++) begin
            int push_pct;
            push_pct = ((c / 250) % 2 == 1) ? 20 : 70;
            if ($urandom_range(0, 99) < 2) cur_play = ~cur_play;
            cur_mute = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) cur_shift = 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 99) < push_pct, 16'($urandom), 16'($urandom),
                          $urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0);
        end

        $display("[TB] reset mid-playback");
        cur_play  = 1'b1;
        cur_mute  = 1'b0;
        cur_shift = 4'd0;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        pushRandom(START_LEVEL);
        idle(2);
        checkOutput("pre_reset_send", 32'(bus.i2s_send_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_send",  32'(bus.i2s_send_o), 32'd0);
        checkOutput("async_rst_level", 32'(fifo_level_o), 32'd0);
        checkOutput("async_rst_play",  32'(playing_o), 32'd0);
        rst = 1'b0;
        resetModel();
        @(posedge clk);
        #1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
